// File: rtl/dbg_bridge_cmd_ctrl.sv
// dbg_bridge_cmd_ctrl
// Command sequencer between the debug UART byte interface and a 32-bit
// memory-mapped bus master. Parses framed read/write commands
// (CMD, LEN, ADDR[31:24..7:0], write data LSB first), issues word accesses with
// an auto-incrementing address and returns read data (LSB first) or ACK_BYTE
// through the UART transmitter.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   uart_rx_ready_i/uart_data_i  received byte available / its value
//   uart_rx_err_i                UART framing error flag
//   uart_rd_o                    consume received byte (also clears error)
//   uart_tx_busy_i               transmitter busy
//   uart_wr_o/uart_data_o        one-cycle transmit strobe / byte to send
//   mem_addr_o                   word address (bits [1:0] always 0)
//   mem_wr_o/mem_rd_o            bus requests, held until mem_ack_i
//   mem_data_o/mem_data_i        write data / read data (valid with ack)
//   mem_ack_i                    access complete
//   busy_o                       high whenever a frame is in progress
module dbg_bridge_cmd_ctrl #(
  parameter int unsigned TIMEOUT_W = 16,
  parameter logic [7:0]  ACK_BYTE  = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        uart_rx_ready_i,
  input  logic [7:0]  uart_data_i,
  input  logic        uart_rx_err_i,
  output logic        uart_rd_o,
  input  logic        uart_tx_busy_i,
  output logic        uart_wr_o,
  output logic [7:0]  uart_data_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic        mem_rd_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i,
  output logic        busy_o
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LEN      = 3'd1;
  localparam logic [2:0] ST_ADDR     = 3'd2;
  localparam logic [2:0] ST_WDATA    = 3'd3;
  localparam logic [2:0] ST_WRITE    = 3'd4;
  localparam logic [2:0] ST_READ     = 3'd5;
  localparam logic [2:0] ST_RDATA_TX = 3'd6;
  localparam logic [2:0] ST_ACK_TX   = 3'd7;

  localparam logic [7:0] CMD_WR = 8'h10;
  localparam logic [7:0] CMD_RD = 8'h11;

  logic [2:0]           state_r;
  logic [2:0]           state_nxt_s;
  logic                 cmd_wr_r;
  logic [7:0]           len_r;
  logic [1:0]           byte_cnt_r;
  logic [23:0]          addr_sh_r;
  logic [31:0]          rdata_r;
  logic [TIMEOUT_W-1:0] to_cnt_r;
  logic                 armed_r;

  logic       rx_state_s;
  logic       cnt_state_s;
  logic       accept_s;
  logic       abort_s;
  logic       timeout_s;
  logic       bus_done_s;
  logic       tx_fire_s;
  logic       last_byte_s;
  logic [7:0] len_dec_s;

  // Byte k of a word, k=0 being the least significant byte.
  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  // Handshake qualifiers derived from the current state and inputs.
  always_comb begin
    rx_state_s  = (state_r == ST_IDLE) || (state_r == ST_LEN) ||
                  (state_r == ST_ADDR) || (state_r == ST_WDATA);
    cnt_state_s = (state_r == ST_LEN) || (state_r == ST_ADDR) || (state_r == ST_WDATA);
    accept_s    = rx_state_s && uart_rx_ready_i && !uart_rx_err_i;
    abort_s     = rx_state_s && uart_rx_err_i;
    timeout_s   = cnt_state_s && !accept_s && !abort_s &&
                  (to_cnt_r == {TIMEOUT_W{1'b1}});
    // armed_r masks an ack in the first request cycle, which is not legal.
    bus_done_s  = ((state_r == ST_WRITE) || (state_r == ST_READ)) && armed_r && mem_ack_i;
    // uart_wr_o in the previous cycle covers the transmitter's busy latency.
    tx_fire_s   = ((state_r == ST_RDATA_TX) || (state_r == ST_ACK_TX)) &&
                  !uart_tx_busy_i && !uart_wr_o;
    last_byte_s = (byte_cnt_r == 2'd3);
    len_dec_s   = len_r - 8'd1;
    // A pending framing error is cleared by a read strobe even without data.
    uart_rd_o   = rx_state_s && (uart_rx_ready_i || uart_rx_err_i);
  end

  // Next-state logic; receive-side aborts override everything else.
  always_comb begin
    state_nxt_s = state_r;
    if (abort_s || timeout_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && ((uart_data_i == CMD_WR) || (uart_data_i == CMD_RD))) state_nxt_s = ST_LEN;
          else state_nxt_s = ST_IDLE;
        end
        ST_LEN: begin
          if (accept_s) state_nxt_s = ST_ADDR;
          else state_nxt_s = ST_LEN;
        end
        ST_ADDR: begin
          if (accept_s && last_byte_s) begin
            if (cmd_wr_r) state_nxt_s = (len_r == 8'd0) ? ST_ACK_TX : ST_WDATA;
            else state_nxt_s = (len_r == 8'd0) ? ST_IDLE : ST_READ;
          end else begin
            state_nxt_s = ST_ADDR;
          end
        end
        ST_WDATA: begin
          if (accept_s && last_byte_s) state_nxt_s = ST_WRITE;
          else state_nxt_s = ST_WDATA;
        end
        ST_WRITE: begin
          if (bus_done_s) state_nxt_s = (len_dec_s == 8'd0) ? ST_ACK_TX : ST_WDATA;
          else state_nxt_s = ST_WRITE;
        end
        ST_READ: begin
          if (bus_done_s) state_nxt_s = ST_RDATA_TX;
          else state_nxt_s = ST_READ;
        end
        ST_RDATA_TX: begin
          if (tx_fire_s && last_byte_s) state_nxt_s = (len_dec_s == 8'd0) ? ST_IDLE : ST_READ;
          else state_nxt_s = ST_RDATA_TX;
        end
        ST_ACK_TX: begin
          if (tx_fire_s) state_nxt_s = ST_IDLE;
          else state_nxt_s = ST_ACK_TX;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register; requests and busy are registered from the next state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= ST_IDLE;
      busy_o      <= 1'b0;
      mem_wr_o    <= 1'b0;
      mem_rd_o    <= 1'b0;
      armed_r     <= 1'b0;
      uart_wr_o   <= 1'b0;
      uart_data_o <= 8'h00;
    end else begin
      state_r   <= state_nxt_s;
      busy_o    <= (state_nxt_s != ST_IDLE);
      mem_wr_o  <= (state_nxt_s == ST_WRITE);
      mem_rd_o  <= (state_nxt_s == ST_READ);
      armed_r   <= (state_nxt_s == state_r) && ((state_r == ST_WRITE) || (state_r == ST_READ));
      uart_wr_o <= tx_fire_s;
      if (tx_fire_s) begin
        uart_data_o <= (state_r == ST_ACK_TX) ? ACK_BYTE : sel_byte(rdata_r, byte_cnt_r);
      end else begin
        uart_data_o <= uart_data_o;
      end
    end
  end

  // Frame datapath: command, length, address, data and the timeout counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cmd_wr_r   <= 1'b0;
      len_r      <= 8'd0;
      byte_cnt_r <= 2'd0;
      addr_sh_r  <= 24'd0;
      mem_addr_o <= 32'd0;
      mem_data_o <= 32'd0;
      rdata_r    <= 32'd0;
      to_cnt_r   <= {TIMEOUT_W{1'b0}};
    end else begin
      // Byte position restarts on every state change.
      if (state_nxt_s != state_r) byte_cnt_r <= 2'd0;
      else if (accept_s || tx_fire_s) byte_cnt_r <= byte_cnt_r + 2'd1;
      else byte_cnt_r <= byte_cnt_r;

      if ((state_nxt_s != state_r) || accept_s || !cnt_state_s) to_cnt_r <= {TIMEOUT_W{1'b0}};
      else to_cnt_r <= to_cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};

      case (state_r)
        ST_IDLE: begin
          if (state_nxt_s == ST_LEN) cmd_wr_r <= (uart_data_i == CMD_WR);
        end
        ST_LEN: begin
          if (accept_s) len_r <= uart_data_i;
        end
        ST_ADDR: begin
          // Address is held in a shadow until complete so mem_addr_o stays aligned.
          if (accept_s && last_byte_s) mem_addr_o <= {addr_sh_r, uart_data_i[7:2], 2'b00};
          else if (accept_s) addr_sh_r <= {addr_sh_r[15:0], uart_data_i};
        end
        ST_WDATA: begin
          if (accept_s) mem_data_o[{byte_cnt_r, 3'b000} +: 8] <= uart_data_i;
        end
        ST_WRITE: begin
          if (bus_done_s) begin
            mem_addr_o <= mem_addr_o + 32'd4;
            len_r      <= len_dec_s;
          end
        end
        ST_READ: begin
          if (bus_done_s) begin
            mem_addr_o <= mem_addr_o + 32'd4;
            rdata_r    <= mem_data_i;
          end
        end
        ST_RDATA_TX: begin
          if (tx_fire_s && last_byte_s) len_r <= len_dec_s;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
